// File: rtl/ifu_prefetch.sv
// ----------------------------------------------------------------------------
// ifu_prefetch
// ----------------------------------------------------------------------------
// Instruction fetch unit with a small prefetch FIFO. It owns the program
// counter and issues sequential word fetches to a synchronous-read instruction
// memory, whose data returns one cycle after the request. Returned words are
// queued with their PC and handed to decode over a valid/ready handshake. A
// redirect loads a new PC, flushes the queue and kills the response that is
// still in flight.
//
// Issue is credit based: a request goes out only while the queued entries plus
// the outstanding response leave room. The FIFO therefore never overflows and
// no response is ever dropped for lack of space.
//
// Optional feature (compile-time macro IFU_MISALIGN_TRAP_EN):
//   defined   - adds output inst_fault. A redirect to a PC that is not 4-byte
//               aligned queues a single faulting entry {pc, 0, fault=1}, then
//               fetch halts until the next redirect or reset.
//   undefined - the two low bits of redirect_pc are cleared on load.
//
// Ports:
//   clock            in   rising-edge clock for all state
//   reset            in   synchronous active-high reset, highest priority
//   imem_req         out  fetch request this cycle
//   imem_addr        out  byte address of the fetch (the PC register)
//   imem_rdata       in   read data, valid the cycle after imem_req
//   redirect_valid   in   load redirect_pc and flush
//   redirect_pc      in   redirect target
//   inst_valid       out  FIFO head is valid
//   inst_ready       in   decode accepts the head
//   Instruction_Code out  head instruction word
//   inst_pc          out  PC of the head instruction
//   inst_fault       out  head entry is a misalignment fault (macro only)
//   fetch_pc         out  current PC register (debug)
// ----------------------------------------------------------------------------
module ifu_prefetch #(
    parameter int                ADDR_W     = 32,
    parameter int                INST_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = {ADDR_W{1'b0}},
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] Instruction_Code,
    output logic [ADDR_W-1:0] inst_pc,
`ifdef IFU_MISALIGN_TRAP_EN
    output logic              inst_fault,
`endif
    output logic [ADDR_W-1:0] fetch_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(3'd4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(2'b11));
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1'b1);
    localparam logic [CNT_W:0]    DEPTH_C    = (CNT_W + 1)'(FIFO_DEPTH);

    // PC and fetch tracking
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] issued_pc_r;
    logic              inflight_r;

    // Prefetch FIFO
    logic [ADDR_W-1:0] fifo_pc_r   [FIFO_DEPTH];
    logic [INST_W-1:0] fifo_inst_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    // Combinational control
    logic              req_s;
    logic              fetch_en_s;
    logic [CNT_W:0]    used_s;
    logic              has_credit_s;
    logic              inst_valid_s;
    logic              pop_s;
    logic              push_s;
    logic [ADDR_W-1:0] push_pc_s;
    logic [INST_W-1:0] push_inst_s;
    logic [ADDR_W-1:0] redirect_load_s;

`ifdef IFU_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_FAULT = 2'b01,
        ST_HALT  = 2'b10
    } fsm_state_t;

    fsm_state_t state_r;
    fsm_state_t state_nxt_s;
    logic       misaligned_s;
    logic       push_fault_s;
    logic       fifo_fault_r [FIFO_DEPTH];

    // Fault FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Fault FSM next state: any redirect restarts fetch or enters the fault
    // path; FAULT lasts exactly one cycle (the entry push), then HALT holds.
    always_comb begin
        state_nxt_s  = state_r;
        misaligned_s = (redirect_pc[1:0] != 2'b00);
        if (redirect_valid) begin
            state_nxt_s = misaligned_s ? ST_FAULT : ST_FETCH;
        end else begin
            case (state_r)
                ST_FETCH: state_nxt_s = ST_FETCH;
                ST_FAULT: state_nxt_s = ST_HALT;
                ST_HALT:  state_nxt_s = ST_HALT;
                default:  state_nxt_s = ST_FETCH;
            endcase
        end
    end

    assign fetch_en_s      = (state_r == ST_FETCH);
    assign redirect_load_s = redirect_pc;
`else
    assign fetch_en_s      = 1'b1;
    assign redirect_load_s = redirect_pc & ALIGN_MASK;
`endif

    // Credit check: queued entries plus the outstanding response must leave
    // room for the response of a new request.
    assign used_s       = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
    assign has_credit_s = (used_s < DEPTH_C);

    // Issue decision; suppressed by reset, by a redirect and outside FETCH
    always_comb begin
        req_s = 1'b0;
        if (!reset && !redirect_valid && has_credit_s && fetch_en_s) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
    end

    // Head handshake; the head is hidden during reset and redirect cycles
    always_comb begin
        inst_valid_s = 1'b0;
        if (!reset && !redirect_valid && (count_r != {CNT_W{1'b0}})) begin
            inst_valid_s = 1'b1;
        end else begin
            inst_valid_s = 1'b0;
        end
    end

    assign pop_s = inst_valid_s & inst_ready;

    // Push source: normally the memory response to last cycle's request; a
    // response arriving during reset or redirect is killed here.
    always_comb begin
        push_s      = 1'b0;
        push_pc_s   = issued_pc_r;
        push_inst_s = imem_rdata;
`ifdef IFU_MISALIGN_TRAP_EN
        push_fault_s = 1'b0;
        if (reset || redirect_valid) begin
            push_s = 1'b0;
        end else if (state_r == ST_FAULT) begin
            // PC already holds the misaligned target; no request was issued
            push_s       = 1'b1;
            push_pc_s    = pc_r;
            push_inst_s  = {INST_W{1'b0}};
            push_fault_s = 1'b1;
        end else begin
            push_s = inflight_r;
        end
`else
        if (reset || redirect_valid) begin
            push_s = 1'b0;
        end else begin
            push_s = inflight_r;
        end
`endif
    end

    // PC, in-flight flag and the PC of the outstanding request
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_r        <= RESET_PC;
            issued_pc_r <= RESET_PC;
            inflight_r  <= 1'b0;
        end else if (redirect_valid) begin
            pc_r       <= redirect_load_s;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= req_s;
            if (req_s) begin
                // Natural modulo-2^ADDR_W wrap
                pc_r        <= pc_r + PC_STEP;
                issued_pc_r <= pc_r;
            end
        end
    end

    // FIFO pointers and occupancy; reset and redirect both flush
    always_ff @(posedge clock) begin
        if (reset || redirect_valid) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents past the count are don't-care, so no reset
    always_ff @(posedge clock) begin
        if (push_s) begin
            fifo_pc_r[wr_ptr_r]   <= push_pc_s;
            fifo_inst_r[wr_ptr_r] <= push_inst_s;
`ifdef IFU_MISALIGN_TRAP_EN
            fifo_fault_r[wr_ptr_r] <= push_fault_s;
`endif
        end
    end

    assign imem_req         = req_s;
    assign imem_addr        = pc_r;
    assign fetch_pc         = pc_r;
    assign inst_valid       = inst_valid_s;
    assign Instruction_Code = fifo_inst_r[rd_ptr_r];
    assign inst_pc          = fifo_pc_r[rd_ptr_r];
`ifdef IFU_MISALIGN_TRAP_EN
    // Gated so a stale fault bit at an empty head never shows
    assign inst_fault = inst_valid_s & fifo_fault_r[rd_ptr_r];
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// ----------------------------------------------------------------------------
// tb_ifu_prefetch
// ----------------------------------------------------------------------------
// Directed bench for ifu_prefetch. Two instances share the control inputs:
// dut0 with RESET_PC = 0 and dut1 with RESET_PC = 0xFFFFFFF8 (PC wrap).
// Each has a one-cycle memory model returning addr ^ 0xA5A50000. A negedge
// monitor records delivered entries and issued requests into queues that the
// directed sequence compares against hand-computed values.
// ----------------------------------------------------------------------------
module tb_ifu_prefetch;

    localparam logic [31:0] MEM_KEY = 32'hA5A5_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_ready;

    logic        req0_s, valid0_s, fault0_s;
    logic [31:0] addr0_s, code0_s, ipc0_s, fpc0_s;
    logic [31:0] rdata0_r;
    logic        req1_s, valid1_s;
    logic [31:0] addr1_s, code1_s, ipc1_s, fpc1_s;
    logic [31:0] rdata1_r;

    logic [31:0] d0_pc_q[$];
    logic [31:0] d0_data_q[$];
    logic        d0_fault_q[$];
    logic [31:0] r0_addr_q[$];
    logic [31:0] d1_pc_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    ifu_prefetch #(
        .ADDR_W(32), .INST_W(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)
    ) dut0 (
        .clock(clock), .reset(reset),
        .imem_req(req0_s), .imem_addr(addr0_s), .imem_rdata(rdata0_r),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(valid0_s), .inst_ready(inst_ready),
        .Instruction_Code(code0_s), .inst_pc(ipc0_s),
`ifdef IFU_MISALIGN_TRAP_EN
        .inst_fault(fault0_s),
`endif
        .fetch_pc(fpc0_s)
    );

`ifndef IFU_MISALIGN_TRAP_EN
    assign fault0_s = 1'b0;
`endif

`ifdef IFU_MISALIGN_TRAP_EN
    logic fault1_s;
`endif

    ifu_prefetch #(
        .ADDR_W(32), .INST_W(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)
    ) dut1 (
        .clock(clock), .reset(reset),
        .imem_req(req1_s), .imem_addr(addr1_s), .imem_rdata(rdata1_r),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(valid1_s), .inst_ready(inst_ready),
        .Instruction_Code(code1_s), .inst_pc(ipc1_s),
`ifdef IFU_MISALIGN_TRAP_EN
        .inst_fault(fault1_s),
`endif
        .fetch_pc(fpc1_s)
    );

    // Synchronous-read memory models: data one cycle after the address
    always @(posedge clock) begin
        rdata0_r <= addr0_s ^ MEM_KEY;
        rdata1_r <= addr1_s ^ MEM_KEY;
    end

    // Monitor: record deliveries and requests away from the active edge
    always @(negedge clock) begin
        if (valid0_s && inst_ready) begin
            d0_pc_q.push_back(ipc0_s);
            d0_data_q.push_back(code0_s);
            d0_fault_q.push_back(fault0_s);
        end
        if (req0_s) begin
            r0_addr_q.push_back(addr0_s);
        end
        if (valid1_s && inst_ready) begin
            d1_pc_q.push_back(ipc1_s);
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge (input drive point)
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_queues();
        d0_pc_q.delete();
        d0_data_q.delete();
        d0_fault_q.delete();
        r0_addr_q.delete();
        d1_pc_q.delete();
    endtask

    // Bounded wait for n deliveries from dut0
    task automatic wait_d0(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while ((d0_pc_q.size() < n) && (k < budget)) begin
            @(posedge clock);
            k++;
        end
        #1;
        check_val(tag, 64'(d0_pc_q.size() >= n), 64'd1);
    endtask

    // Compare dut0 delivery i against a pc; data must be pc ^ key (or 0 for fault)
    task automatic check_d0(input string tag, input int i, input logic [31:0] pc,
                            input logic [31:0] data, input logic fault);
        logic [31:0] got_pc, got_data;
        logic        got_fault;
        got_pc    = (i < d0_pc_q.size()) ? d0_pc_q[i] : 32'hDEAD_BEEF;
        got_data  = (i < d0_data_q.size()) ? d0_data_q[i] : 32'hDEAD_BEEF;
        got_fault = (i < d0_fault_q.size()) ? d0_fault_q[i] : 1'bx;
        check_val({tag, "_pc"}, 64'(got_pc), 64'(pc));
        check_val({tag, "_data"}, 64'(got_data), 64'(data));
        check_val({tag, "_fault"}, 64'(got_fault), 64'(fault));
    endtask

    logic [31:0] wrap_pc_tbl [4];
    logic [31:0] got32;

    initial begin
        wrap_pc_tbl[0] = 32'hFFFF_FFF8;
        wrap_pc_tbl[1] = 32'hFFFF_FFFC;
        wrap_pc_tbl[2] = 32'h0000_0000;
        wrap_pc_tbl[3] = 32'h0000_0004;

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        inst_ready     = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        // Reset state
        @(negedge clock);
        check_val("rst_req", 64'(req0_s), 64'd0);
        check_val("rst_valid", 64'(valid0_s), 64'd0);
        check_val("rst_fetch_pc0", 64'(fpc0_s), 64'h0);
        check_val("rst_fetch_pc1", 64'(fpc1_s), 64'hFFFF_FFF8);

        // Test 1: streaming with inst_ready=1
        step();
        reset = 1'b0;
        clear_queues();
        @(negedge clock);
        check_val("t1_req_c0", 64'(req0_s), 64'd1);
        check_val("t1_addr_c0", 64'(addr0_s), 64'h0);
        check_val("t1_valid_c0", 64'(valid0_s), 64'd0);
        step();
        @(negedge clock);
        check_val("t1_valid_c1", 64'(valid0_s), 64'd0);
        check_val("t1_addr_c1", 64'(addr0_s), 64'h4);
        step();
        @(negedge clock);
        check_val("t1_valid_c2", 64'(valid0_s), 64'd1);
        check_val("t1_pc_c2", 64'(ipc0_s), 64'h0);
        check_val("t1_code_c2", 64'(code0_s), 64'(MEM_KEY));
        wait_d0("t1_wait", 6, 20);
        for (int i = 0; i < 6; i++) begin
            check_d0("t1_d", i, 32'(i * 4), 32'(i * 4) ^ MEM_KEY, 1'b0);
        end

        // Test 5 (second instance, same run): PC wraps through zero
        for (int i = 0; i < 4; i++) begin
            got32 = (i < d1_pc_q.size()) ? d1_pc_q[i] : 32'hDEAD_BEEF;
            check_val("t5_wrap_pc", 64'(got32), 64'(wrap_pc_tbl[i]));
        end

        // Test 2: decode stalled for 10 cycles after reset
        step();
        reset      = 1'b1;
        inst_ready = 1'b0;
        step();
        reset = 1'b0;
        clear_queues();
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (c == 9) begin
                check_val("t2_req_full", 64'(req0_s), 64'd0);
                check_val("t2_valid_hold", 64'(valid0_s), 64'd1);
                check_val("t2_pc_hold", 64'(ipc0_s), 64'h0);
                check_val("t2_code_hold", 64'(code0_s), 64'(MEM_KEY));
            end
            step();
        end
        check_val("t2_nreq", 64'(r0_addr_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            got32 = (i < r0_addr_q.size()) ? r0_addr_q[i] : 32'hDEAD_BEEF;
            check_val("t2_req_addr", 64'(got32), 64'(i * 4));
        end
        r0_addr_q.delete();
        inst_ready = 1'b1;
        wait_d0("t2_wait", 6, 20);
        for (int i = 0; i < 6; i++) begin
            check_d0("t2_d", i, 32'(i * 4), 32'(i * 4) ^ MEM_KEY, 1'b0);
        end
        got32 = (r0_addr_q.size() > 0) ? r0_addr_q[0] : 32'hDEAD_BEEF;
        check_val("t2_resume_addr", 64'(got32), 64'h10);

        // Test 3: redirect with 3 entries queued and one request in flight
        inst_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (4) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        clear_queues();
        @(negedge clock);
        check_val("t3_valid_redir", 64'(valid0_s), 64'd0);
        check_val("t3_req_redir", 64'(req0_s), 64'd0);
        step();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        @(negedge clock);
        check_val("t3_fetch_pc", 64'(fpc0_s), 64'h100);
        check_val("t3_req_addr", 64'(addr0_s), 64'h100);
        check_val("t3_valid_flushed", 64'(valid0_s), 64'd0);
        wait_d0("t3_wait", 3, 20);
        for (int i = 0; i < 3; i++) begin
            check_d0("t3_d", i, 32'h100 + 32'(i * 4), (32'h100 + 32'(i * 4)) ^ MEM_KEY, 1'b0);
        end

        // Test 4: reset mid-stream with a request in flight
        step();
        @(negedge clock);
        check_val("t4_pre_req", 64'(req0_s), 64'd1);
        step();
        reset = 1'b1;
        clear_queues();
        @(negedge clock);
        check_val("t4_req_rst", 64'(req0_s), 64'd0);
        check_val("t4_valid_rst", 64'(valid0_s), 64'd0);
        step();
        reset = 1'b0;
        @(negedge clock);
        check_val("t4_fetch_pc", 64'(fpc0_s), 64'h0);
        check_val("t4_valid_after", 64'(valid0_s), 64'd0);
        wait_d0("t4_wait", 2, 20);
        check_d0("t4_d0", 0, 32'h0, MEM_KEY, 1'b0);
        check_d0("t4_d1", 1, 32'h4, 32'h4 ^ MEM_KEY, 1'b0);

        // Test 6: redirect to a misaligned target
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        clear_queues();
        @(negedge clock);
        check_val("t6_valid_redir", 64'(valid0_s), 64'd0);
        step();
        redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
        @(negedge clock);
        check_val("t6_req_fault", 64'(req0_s), 64'd0);
        check_val("t6_fetch_pc", 64'(fpc0_s), 64'h102);
        step();
        @(negedge clock);
        check_val("t6_fault_valid", 64'(valid0_s), 64'd1);
        check_val("t6_fault_pc", 64'(ipc0_s), 64'h102);
        check_val("t6_fault_bit", 64'(fault0_s), 64'd1);
        check_val("t6_fault_code", 64'(code0_s), 64'h0);
        repeat (3) step();
        @(negedge clock);
        check_val("t6_halt_req", 64'(req0_s), 64'd0);
        check_val("t6_halt_valid", 64'(valid0_s), 64'd0);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        clear_queues();
        step();
        redirect_valid = 1'b0;
        @(negedge clock);
        check_val("t6_resume_req", 64'(req0_s), 64'd1);
        wait_d0("t6_wait", 1, 20);
        check_d0("t6_resume", 0, 32'h200, 32'h200 ^ MEM_KEY, 1'b0);
`else
        @(negedge clock);
        check_val("t6_fetch_pc", 64'(fpc0_s), 64'h100);
        check_val("t6_req", 64'(req0_s), 64'd1);
        wait_d0("t6_wait", 2, 20);
        check_d0("t6_d0", 0, 32'h100, 32'h100 ^ MEM_KEY, 1'b0);
        check_d0("t6_d1", 1, 32'h104, 32'h104 ^ MEM_KEY, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Parametrised next-generation instruction fetch unit.
- Owns the program counter and issues sequential fetches to an external synchronous-read instruction memory.
- Buffers returned instructions in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Supports PC redirect (branch/jump/trap) with flush of stale fetches; sits between instruction memory and the decode stage.

Parameters:
ADDR_W, 32, PC and memory byte-address width
INST_W, 32, instruction word width
RESET_PC, 0, PC value loaded on reset (must be 4-byte aligned)
FIFO_DEPTH, 4, prefetch FIFO entries; power of two, >=2

Ports:
clock  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request this cycle
imem_addr  output  ADDR_W  byte address of the fetch (equals PC)
imem_rdata  input  INST_W  read data, valid exactly 1 cycle after imem_req
redirect_valid  input  1  load new PC and flush
redirect_pc  input  ADDR_W  redirect target
inst_valid  output  1  FIFO head is valid
inst_ready  input  1  decode accepts the head
Instruction_Code  output  INST_W  head instruction
inst_pc  output  ADDR_W  PC of the head instruction
fetch_pc  output  ADDR_W  current PC register (debug)

Behaviour:
- Reset (synchronous, takes priority over everything):
  - PC <= RESET_PC; FIFO count, pointers and in-flight flag <= 0.
  - imem_req=0 and inst_valid=0 while reset is high.
  - A response in flight during reset is discarded.
- State:
  - PC register.
  - 1-bit inflight flag: a request was issued last cycle.
  - FIFO of {pc, instruction} with rd/wr pointers and count (0..FIFO_DEPTH).
- Issue rule: imem_req = ~reset & ~redirect_valid & (count + inflight < FIFO_DEPTH).
  - imem_addr = PC.
  - On issue: PC <= PC + 4, modulo 2^ADDR_W (wraps FFFFFFFC -> 0); inflight <= 1. Otherwise inflight <= 0.
  - Credit-based issue means the FIFO never overflows and responses are never dropped for lack of space.
- Response: the cycle after an issue, push {issued PC, imem_rdata} into the FIFO. The issued PC is held in an internal register.
- Output:
  - inst_valid = (count != 0) & ~redirect_valid.
  - Instruction_Code and inst_pc are driven combinationally from the FIFO head.
  - Pop on inst_valid & inst_ready.
  - Simultaneous push and pop leaves count unchanged. Pop is legal when count=FIFO_DEPTH; push into a full FIFO cannot occur.
- Redirect (redirect_valid=1 and reset=0):
  - PC <= redirect_pc; FIFO is flushed (count and pointers <= 0).
  - The in-flight response arriving next cycle is killed (not pushed).
  - No request and no pop in the redirect cycle.
  - First request to redirect_pc is issued the following cycle.
- Latency: request at cycle N, entry visible (inst_valid=1) at cycle N+2. Sustained throughput is 1 instruction/cycle when inst_ready=1.
- Back-to-back redirects: the last one wins; each flushes again.
- Stability: Instruction_Code/inst_pc hold stable while inst_valid=1 and inst_ready=0.

Optional Feature:
IFU_MISALIGN_TRAP_EN
- Defined:
  - Adds output inst_fault (1 bit, reset 0), stored per FIFO entry.
  - A redirect with redirect_pc[1:0] != 0 loads PC and enters FAULT state. FAULT pushes one entry {pc=redirect_pc, Instruction_Code=0, fault=1} the next cycle without asserting imem_req.
  - Fetch then halts (imem_req=0) until the next redirect or reset.
- Undefined:
  - redirect_pc[1:0] is forced to 00 on load; no inst_fault port; no FAULT state.

Test Plan:
1. Release reset, inst_ready=1, memory returns word = addr ^ 0xA5A50000.
   -> imem_req=1 addr 0x0 in cycle 0; inst_valid first high in cycle 2 with inst_pc 0x0; then 0x4, 0x8, … one per cycle, correct data.
2. inst_ready=0 for 10 cycles after reset.
   -> exactly 4 requests (0x0–0xC), then imem_req=0; count=4. Raise inst_ready -> 0x0, 0x4, 0x8, 0xC delivered in order, no loss or duplicate; fetch resumes at 0x10.
3. FIFO holds 3 entries and a request is in flight; pulse redirect_valid with redirect_pc=0x100.
   -> inst_valid=0 in the redirect cycle; the next delivered inst_pc is 0x100, then 0x104; no stale PCs appear.
4. Reset asserted mid-stream with inst_ready=1 and a request in flight.
   -> next cycle inst_valid=0 and fetch_pc=RESET_PC; the in-flight data is never delivered; the next delivered inst_pc is RESET_PC.
5. RESET_PC=0xFFFFFFF8, inst_ready=1.
   -> delivered inst_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
6. Redirect to 0x102.
   -> with IFU_MISALIGN_TRAP_EN: one entry inst_fault=1, inst_pc=0x102, and imem_req stays 0 until a redirect to 0x200, which resumes fetch. Without the macro: delivered inst_pc=0x100.
